// File: rtl/riscV_unrn_pkg.sv
// -----------------------------------------------------------------------------
// riscV_unrn_pkg
// Shared types and constants for the trap/MRET control path.
//   trap_state_t : trap controller FSM encoding
//   CAUSE_*      : mcause values for the supported trap sources
//   trap_evt_t   : event record from the priority encoder to the controller
// -----------------------------------------------------------------------------
package riscV_unrn_pkg;

  typedef enum logic [1:0] {
    RUN           = 2'd0,
    TRAP          = 2'd1,
    REDIRECT      = 2'd2,
    MRET_REDIRECT = 2'd3
  } trap_state_t;

  localparam logic [31:0] CAUSE_FETCH_MIS  = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] CAUSE_LOAD_MIS   = 32'd4;
  localparam logic [31:0] CAUSE_STORE_MIS  = 32'd6;
  localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
  localparam logic [31:0] CAUSE_MTIMER_INT = 32'h8000_0007;

  // valid   : a trap (interrupt or exception) was selected
  // is_mret : no trap, but the committing instruction is an MRET
  // is_irq  : the selected trap is the timer interrupt
  typedef struct packed {
    logic        valid;
    logic        is_mret;
    logic        is_irq;
    logic [31:0] cause;
    logic [31:0] info;
  } trap_evt_t;

endpackage

// File: rtl/trap_prio_enc.sv
// -----------------------------------------------------------------------------
// trap_prio_enc
// Combinational priority selection of the trap/MRET event at commit.
//   mtime_exc_i        : pending enabled timer interrupt (needs no instruction)
//   instr_valid_i      : qualifies every sync flag and mret_i
//   exc_*_i, mret_i    : sync exception flags / MRET commit
//   pc_i, instr_bits_i, fault_addr_i : sources for the trap info value
//   evt_o              : selected {valid, is_mret, is_irq, cause, info}
// -----------------------------------------------------------------------------
module trap_prio_enc
  import riscV_unrn_pkg::*;
(
  input  logic        mtime_exc_i,
  input  logic        instr_valid_i,
  input  logic        exc_fetch_mis_i,
  input  logic        exc_illegal_i,
  input  logic        exc_ebreak_i,
  input  logic        exc_ecall_i,
  input  logic        exc_load_mis_i,
  input  logic        exc_store_mis_i,
  input  logic        mret_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_bits_i,
  input  logic [31:0] fault_addr_i,
  output trap_evt_t   evt_o
);

  always_comb begin
    // NOTE: every field gets a default before the priority chain, so no path
    // leaves a field unassigned and no latch is inferred.
    evt_o = '0;
    if (mtime_exc_i) begin
      evt_o.valid  = 1'b1;
      evt_o.is_irq = 1'b1;
      evt_o.cause  = CAUSE_MTIMER_INT;
    end else if (instr_valid_i) begin
      if (exc_fetch_mis_i) begin
        evt_o.valid = 1'b1;
        evt_o.cause = CAUSE_FETCH_MIS;
        evt_o.info  = fault_addr_i;
      end else if (exc_illegal_i) begin
        evt_o.valid = 1'b1;
        evt_o.cause = CAUSE_ILLEGAL;
        evt_o.info  = instr_bits_i;
      end else if (exc_ebreak_i) begin
        evt_o.valid = 1'b1;
        evt_o.cause = CAUSE_BREAKPOINT;
        evt_o.info  = pc_i;
      end else if (exc_ecall_i) begin
        evt_o.valid = 1'b1;
        evt_o.cause = CAUSE_ECALL_M;
      end else if (exc_load_mis_i) begin
        evt_o.valid = 1'b1;
        evt_o.cause = CAUSE_LOAD_MIS;
        evt_o.info  = fault_addr_i;
      end else if (exc_store_mis_i) begin
        evt_o.valid = 1'b1;
        evt_o.cause = CAUSE_STORE_MIS;
        evt_o.info  = fault_addr_i;
      end else if (mret_i) begin
        evt_o.is_mret = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Commit-stage trap and MRET controller. Selects the highest-priority event,
// flushes younger instructions, reports mcause/mtval/mepc to the CSR unit with
// a one-cycle strobe, then requests a fetch redirect to mtvec (or mepc for
// MRET) and holds it until fetch accepts.
//   clk, rst                 : clock, synchronous active-low reset
//   instr_valid_i, pc_i, instr_bits_i, fault_addr_i : committing instruction
//   exc_*_i, mret_i, mtime_exc_i : event sources
//   mtvec_i, mepc_i          : current CSR values
//   redirect_ready_i         : fetch accepts redirect
//   jumpingToMtvec_o         : trap-commit strobe (TRAP state)
//   excCause_o, trapInfo_o, pc_o : latched mcause / mtval / mepc values
//   redirect_valid_o, redirect_pc_o : redirect request and word-aligned target
//   stall_o, flush_o, mret_o : commit freeze, younger-kill, MRET strobe
// -----------------------------------------------------------------------------
module trap_ctrl
  import riscV_unrn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_bits_i,
  input  logic [31:0] fault_addr_i,
  input  logic        exc_fetch_mis_i,
  input  logic        exc_illegal_i,
  input  logic        exc_ebreak_i,
  input  logic        exc_ecall_i,
  input  logic        exc_load_mis_i,
  input  logic        exc_store_mis_i,
  input  logic        mret_i,
  input  logic        mtime_exc_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic        redirect_ready_i,
  output logic        jumpingToMtvec_o,
  output logic [31:0] excCause_o,
  output logic [31:0] trapInfo_o,
  output logic [31:0] pc_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        mret_o
);

  trap_state_t state_q, state_d;
  trap_evt_t   evt;

  logic [31:0] cause_q;
  logic [31:0] info_q;
  logic [31:0] pc_q;
  logic [31:0] target_q;
  logic [31:0] last_pc_q;   // PC of the most recent instruction seen in RUN

  trap_prio_enc u_prio (
    .mtime_exc_i     (mtime_exc_i),
    .instr_valid_i   (instr_valid_i),
    .exc_fetch_mis_i (exc_fetch_mis_i),
    .exc_illegal_i   (exc_illegal_i),
    .exc_ebreak_i    (exc_ebreak_i),
    .exc_ecall_i     (exc_ecall_i),
    .exc_load_mis_i  (exc_load_mis_i),
    .exc_store_mis_i (exc_store_mis_i),
    .mret_i          (mret_i),
    .pc_i            (pc_i),
    .instr_bits_i    (instr_bits_i),
    .fault_addr_i    (fault_addr_i),
    .evt_o           (evt)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Next-state logic. Event inputs only matter in RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (evt.valid)        state_d = TRAP;
        else if (evt.is_mret) state_d = MRET_REDIRECT;
      end
      TRAP:                   state_d = REDIRECT;
      REDIRECT, MRET_REDIRECT: begin
        if (redirect_ready_i) state_d = RUN;
      end
      default:                state_d = RUN;
    endcase
  end

  // Output logic.
  always_comb begin
    jumpingToMtvec_o = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    flush_o          = 1'b0;
    mret_o           = 1'b0;
    stall_o          = (state_q != RUN);
    unique case (state_q)
      RUN: begin
        flush_o = evt.valid | evt.is_mret;
        mret_o  = evt.is_mret;
      end
      TRAP: jumpingToMtvec_o = 1'b1;
      REDIRECT, MRET_REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = {target_q[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  // The CSR-facing values are register outputs: valid during TRAP and held
  // until the next trap overwrites them.
  assign excCause_o = cause_q;
  assign trapInfo_o = info_q;
  assign pc_o       = pc_q;

  // Event latches and redirect target.
  always_ff @(posedge clk) begin
    // NOTE: this register set is small, so all of it is reset to give the
    // CSR interface a defined all-zero value after reset.
    if (!rst) begin
      cause_q   <= '0;
      info_q    <= '0;
      pc_q      <= '0;
      target_q  <= '0;
      last_pc_q <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (instr_valid_i) last_pc_q <= pc_i;
          if (evt.valid) begin
            cause_q  <= evt.cause;
            info_q   <= evt.info;
            // An interrupt with no committing instruction resumes at the
            // last instruction seen; otherwise the committing one is suppressed.
            pc_q     <= (evt.is_irq && !instr_valid_i) ? last_pc_q : pc_i;
            target_q <= mtvec_i;
          end else if (evt.is_mret) begin
            target_q <= mepc_i;
          end
        end
        // mtvec may have been written by the instruction ahead; take it late.
        TRAP:    target_q <= mtvec_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
// Directed self-checking bench for trap_ctrl.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid_i;
  logic [31:0] pc_i, instr_bits_i, fault_addr_i;
  logic        exc_fetch_mis_i, exc_illegal_i, exc_ebreak_i, exc_ecall_i;
  logic        exc_load_mis_i, exc_store_mis_i, mret_i, mtime_exc_i;
  logic [31:0] mtvec_i, mepc_i;
  logic        redirect_ready_i;
  logic        jumpingToMtvec_o;
  logic [31:0] excCause_o, trapInfo_o, pc_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        stall_o, flush_o, mret_o;

  int checks   = 0;
  int failures = 0;

  trap_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .instr_valid_i    (instr_valid_i),
    .pc_i             (pc_i),
    .instr_bits_i     (instr_bits_i),
    .fault_addr_i     (fault_addr_i),
    .exc_fetch_mis_i  (exc_fetch_mis_i),
    .exc_illegal_i    (exc_illegal_i),
    .exc_ebreak_i     (exc_ebreak_i),
    .exc_ecall_i      (exc_ecall_i),
    .exc_load_mis_i   (exc_load_mis_i),
    .exc_store_mis_i  (exc_store_mis_i),
    .mret_i           (mret_i),
    .mtime_exc_i      (mtime_exc_i),
    .mtvec_i          (mtvec_i),
    .mepc_i           (mepc_i),
    .redirect_ready_i (redirect_ready_i),
    .jumpingToMtvec_o (jumpingToMtvec_o),
    .excCause_o       (excCause_o),
    .trapInfo_o       (trapInfo_o),
    .pc_o             (pc_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .mret_o           (mret_o)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    instr_valid_i   = 1'b0;
    exc_fetch_mis_i = 1'b0;
    exc_illegal_i   = 1'b0;
    exc_ebreak_i    = 1'b0;
    exc_ecall_i     = 1'b0;
    exc_load_mis_i  = 1'b0;
    exc_store_mis_i = 1'b0;
    mret_i          = 1'b0;
    mtime_exc_i     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_events();
    pc_i = '0; instr_bits_i = '0; fault_addr_i = '0;
    mtvec_i = '0; mepc_i = '0; redirect_ready_i = 1'b1;
    step(); step();
    checks++;
    if ({jumpingToMtvec_o, redirect_valid_o, stall_o, flush_o, mret_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=00000",
               {jumpingToMtvec_o, redirect_valid_o, stall_o, flush_o, mret_o});
    end
    checks++;
    if ({excCause_o, trapInfo_o, pc_o, redirect_pc_o} !== 128'd0) begin
      failures++;
      $display("FAIL reset_values cause=%h info=%h pc=%h rpc=%h exp=0",
               excCause_o, trapInfo_o, pc_o, redirect_pc_o);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_illegal();
    instr_valid_i = 1'b1; exc_illegal_i = 1'b1;
    pc_i = 32'h100; instr_bits_i = 32'hFFFF_FFFF; mtvec_i = 32'h400;
    #1;
    checks++;
    if (flush_o !== 1'b1 || stall_o !== 1'b0) begin
      failures++;
      $display("FAIL illegal_flush flush=%b stall=%b exp flush=1 stall=0", flush_o, stall_o);
    end
    step();
    clear_events();
    checks++;
    if (jumpingToMtvec_o !== 1'b1 || stall_o !== 1'b1 || redirect_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL illegal_trap_strobe jump=%b stall=%b rv=%b exp 1 1 0",
               jumpingToMtvec_o, stall_o, redirect_valid_o);
    end
    checks++;
    if (excCause_o !== 32'd2 || trapInfo_o !== 32'hFFFF_FFFF || pc_o !== 32'h100) begin
      failures++;
      $display("FAIL illegal_csr cause=%h info=%h pc=%h exp 2 ffffffff 100",
               excCause_o, trapInfo_o, pc_o);
    end
    step();
    checks++;
    if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h400 || jumpingToMtvec_o !== 1'b0) begin
      failures++;
      $display("FAIL illegal_redirect rv=%b rpc=%h jump=%b exp 1 400 0",
               redirect_valid_o, redirect_pc_o, jumpingToMtvec_o);
    end
    step();
    checks++;
    if (redirect_valid_o !== 1'b0 || stall_o !== 1'b0 || excCause_o !== 32'd2) begin
      failures++;
      $display("FAIL illegal_return rv=%b stall=%b cause=%h exp 0 0 2",
               redirect_valid_o, stall_o, excCause_o);
    end
  endtask

  task automatic test_priority();
    // ecall beats load_mis.
    instr_valid_i = 1'b1; exc_ecall_i = 1'b1; exc_load_mis_i = 1'b1;
    pc_i = 32'h200; fault_addr_i = 32'h55; mtvec_i = 32'h400;
    step();
    clear_events();
    checks++;
    if (excCause_o !== 32'd11 || trapInfo_o !== 32'd0 || pc_o !== 32'h200) begin
      failures++;
      $display("FAIL prio_ecall cause=%h info=%h pc=%h exp b 0 200", excCause_o, trapInfo_o, pc_o);
    end
    step(); step();
    // timer beats illegal; committing instruction is suppressed.
    instr_valid_i = 1'b1; exc_illegal_i = 1'b1; mtime_exc_i = 1'b1;
    pc_i = 32'h300; instr_bits_i = 32'h1234_5678;
    step();
    clear_events();
    checks++;
    if (excCause_o !== 32'h8000_0007 || trapInfo_o !== 32'd0 || pc_o !== 32'h300) begin
      failures++;
      $display("FAIL prio_timer cause=%h info=%h pc=%h exp 80000007 0 300",
               excCause_o, trapInfo_o, pc_o);
    end
    step(); step();
    // timer with no instruction resumes at the last committing PC.
    mtime_exc_i = 1'b1; pc_i = 32'h999;
    step();
    clear_events();
    checks++;
    if (excCause_o !== 32'h8000_0007 || pc_o !== 32'h300) begin
      failures++;
      $display("FAIL timer_idle_pc cause=%h pc=%h exp 80000007 300", excCause_o, pc_o);
    end
    step(); step();
  endtask

  task automatic test_back_to_back_backpressure();
    int handshakes;
    handshakes = 0;
    instr_valid_i = 1'b1; exc_ebreak_i = 1'b1;
    pc_i = 32'h500; mtvec_i = 32'h40F; redirect_ready_i = 1'b0;
    step();
    clear_events();
    checks++;
    if (excCause_o !== 32'd3 || trapInfo_o !== 32'h500) begin
      failures++;
      $display("FAIL ebreak_csr cause=%h info=%h exp 3 500", excCause_o, trapInfo_o);
    end
    step();
    mtvec_i = 32'h800;  // must not disturb the held target
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h40C || stall_o !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d rv=%b rpc=%h stall=%b exp 1 40c 1",
                 i, redirect_valid_o, redirect_pc_o, stall_o);
      end
      step();
    end
    redirect_ready_i = 1'b1;
    #1;
    if (redirect_valid_o === 1'b1) handshakes++;
    step();
    if (redirect_valid_o === 1'b1) handshakes++;
    checks++;
    if (handshakes !== 1 || stall_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_single_handshake handshakes=%0d stall=%b exp 1 0", handshakes, stall_o);
    end
  endtask

  task automatic test_mret();
    instr_valid_i = 1'b1; mret_i = 1'b1; mepc_i = 32'h208; pc_i = 32'h700;
    #1;
    checks++;
    if (mret_o !== 1'b1 || flush_o !== 1'b1) begin
      failures++;
      $display("FAIL mret_pulse mret=%b flush=%b exp 1 1", mret_o, flush_o);
    end
    step();
    clear_events();
    checks++;
    if (mret_o !== 1'b0 || flush_o !== 1'b0 || redirect_valid_o !== 1'b1 ||
        redirect_pc_o !== 32'h208 || jumpingToMtvec_o !== 1'b0) begin
      failures++;
      $display("FAIL mret_redirect mret=%b flush=%b rv=%b rpc=%h jump=%b exp 0 0 1 208 0",
               mret_o, flush_o, redirect_valid_o, redirect_pc_o, jumpingToMtvec_o);
    end
    step();
    checks++;
    if (redirect_valid_o !== 1'b0 || stall_o !== 1'b0) begin
      failures++;
      $display("FAIL mret_return rv=%b stall=%b exp 0 0", redirect_valid_o, stall_o);
    end
  endtask

  task automatic test_ignored_events();
    instr_valid_i = 1'b1; exc_store_mis_i = 1'b1;
    pc_i = 32'h600; fault_addr_i = 32'h601; mtvec_i = 32'h400;
    redirect_ready_i = 1'b0;
    step();
    // In TRAP: raise timer and an MRET on a new PC; all must be ignored.
    clear_events();
    mtime_exc_i = 1'b1; instr_valid_i = 1'b1; mret_i = 1'b1; pc_i = 32'h777;
    #1;
    checks++;
    if (excCause_o !== 32'd6 || trapInfo_o !== 32'h601 || flush_o !== 1'b0 || mret_o !== 1'b0) begin
      failures++;
      $display("FAIL ignore_in_trap cause=%h info=%h flush=%b mret=%b exp 6 601 0 0",
               excCause_o, trapInfo_o, flush_o, mret_o);
    end
    step();
    checks++;
    if (redirect_valid_o !== 1'b1 || flush_o !== 1'b0 || mret_o !== 1'b0) begin
      failures++;
      $display("FAIL ignore_in_redirect rv=%b flush=%b mret=%b exp 1 0 0",
               redirect_valid_o, flush_o, mret_o);
    end
    redirect_ready_i = 1'b1;
    step();
    // Back in RUN with the timer still pending: taken this cycle.
    instr_valid_i = 1'b0; mret_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || flush_o !== 1'b1) begin
      failures++;
      $display("FAIL pending_timer_taken stall=%b flush=%b exp 0 1", stall_o, flush_o);
    end
    step();
    clear_events();
    checks++;
    if (jumpingToMtvec_o !== 1'b1 || excCause_o !== 32'h8000_0007 || pc_o !== 32'h600) begin
      failures++;
      $display("FAIL pending_timer_csr jump=%b cause=%h pc=%h exp 1 80000007 600",
               jumpingToMtvec_o, excCause_o, pc_o);
    end
    step(); step();
  endtask

  task automatic test_reset_in_redirect();
    instr_valid_i = 1'b1; exc_ecall_i = 1'b1; pc_i = 32'h900;
    mtvec_i = 32'h404; redirect_ready_i = 1'b0;
    step();
    clear_events();
    step();
    checks++;
    if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h404) begin
      failures++;
      $display("FAIL rst_pre_redirect rv=%b rpc=%h exp 1 404", redirect_valid_o, redirect_pc_o);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({jumpingToMtvec_o, redirect_valid_o, stall_o, flush_o, mret_o} !== 5'b0 ||
        {excCause_o, trapInfo_o, pc_o, redirect_pc_o} !== 128'd0) begin
      failures++;
      $display("FAIL rst_in_redirect strobes=%b cause=%h info=%h pc=%h rpc=%h exp all 0",
               {jumpingToMtvec_o, redirect_valid_o, stall_o, flush_o, mret_o},
               excCause_o, trapInfo_o, pc_o, redirect_pc_o);
    end
    rst = 1'b1;
    redirect_ready_i = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_priority();
    test_back_to_back_backpressure();
    test_mret();
    test_ignored_events();
    test_reset_in_redirect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
